// File: rtl/demux_collect_pkg.sv
// Shared definitions for the 1-to-N demultiplexing collector.
//   N_DEFAULT / SEL_W_DEFAULT : default vector width and index width.
//   collect_state_t           : collector FSM states.
package demux_collect_pkg;

  localparam int unsigned N_DEFAULT     = 256;
  localparam int unsigned SEL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } collect_state_t;

endpackage : demux_collect_pkg

// File: rtl/demux_onehot_dec.sv
// Combinational one-hot write-enable decoder.
//   sel_i    : bit index to enable.
//   en_i     : accept strobe; when low no enable is raised.
//   onehot_o : N-bit enable vector, at most one bit set.
module demux_onehot_dec #(
  parameter int unsigned N     = 256,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule : demux_onehot_dec

// File: rtl/demux1to256_collector.sv
// Sequential 1-to-N demultiplexer/collector. Each accepted 1-bit beat is
// written into one bit of a registered N-bit vector, addressed either by
// `sel` or by an internal auto-increment pointer. A frame ends after N
// accepted beats, signalled by a one-cycle frame_done pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begins a frame from IDLE
//   clear       : synchronous clear of vector, counters and FSM
//   auto_mode   : 1 = write at internal pointer, 0 = write at sel
//   sel         : explicit target index
//   in_valid    : beat valid; in_bit : beat data; in_ready : accepting (FILL)
//   out_vec     : collected vector
//   frame_done  : pulse for one cycle after the Nth beat
//   busy        : high while in FILL
//   beat_cnt    : beats accepted in current frame (0..N)
//   vec_parity  : XOR of out_vec, present only when DEMUX_COLLECT_PARITY_EN
//                 is defined
module demux1to256_collector
  import demux_collect_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             auto_mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [N-1:0]     out_vec,
  output logic             frame_done,
  output logic             busy,
  output logic [SEL_W:0]   beat_cnt
`ifdef DEMUX_COLLECT_PARITY_EN
  ,
  output logic             vec_parity
`endif
);

  localparam int unsigned CNT_W = SEL_W + 1;

  collect_state_t   state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     vec_q, vec_d;
  logic [SEL_W-1:0] idx;
  logic             accept;
  logic [N-1:0]     we;

  // clear suppresses the accept so a same-cycle beat never writes.
  assign accept = (state_q == FILL) && in_valid && !clear;
  assign idx    = auto_mode ? ptr_q : sel;

  demux_onehot_dec #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i    (idx),
    .en_i     (accept),
    .onehot_o (we)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vec_d   = (vec_q & ~we) | (we & {N{in_bit}});
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          ptr_d = ptr_q + SEL_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      vec_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

`ifdef DEMUX_COLLECT_PARITY_EN
  logic par_q, par_d;

  // Incremental update: only the written bit can change the parity.
  always_comb begin
    par_d = par_q ^ (accept & (vec_q[idx] ^ in_bit));
    if (clear) begin
      par_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign vec_parity = par_q;
`endif

  assign in_ready   = (state_q == FILL);
  assign busy       = (state_q == FILL);
  assign frame_done = (state_q == DONE);
  assign out_vec    = vec_q;
  assign beat_cnt   = cnt_q;

endmodule : demux1to256_collector

// File: tb/tb_demux1to256_collector.sv
module tb_demux1to256_collector;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         clear;
  logic         auto_mode;
  logic [7:0]   sel;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic [255:0] out_vec;
  logic         frame_done;
  logic         busy;
  logic [8:0]   beat_cnt;
`ifdef DEMUX_COLLECT_PARITY_EN
  logic         vec_parity;
`endif

  int checks = 0;
  int errors = 0;

  demux1to256_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .auto_mode  (auto_mode),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_vec    (out_vec),
    .frame_done (frame_done),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
`ifdef DEMUX_COLLECT_PARITY_EN
    ,
    .vec_parity (vec_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        clr;
    logic        am;
    logic        vld;
    logic        b;
    logic [7:0]  s;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic [8:0]  e_cnt;
    logic [15:0] e_lo;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic am, input logic [7:0] s, input logic b);
    auto_mode = am;
    sel       = s;
    in_bit    = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [255:0] exp_vec;
  int           bad;

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; auto_mode = 1'b0;
    sel = '0; in_valid = 1'b0; in_bit = 1'b0;

    //                st  clr am  vld b     s      rdy  bsy  dn   cnt    lo
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 9'd0, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 9'd1, 16'h0008};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 9'd2, 16'h000A};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 9'd2, 16'h000A};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 9'd3, 16'h000E};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 9'd4, 16'h0006};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 9'd0, 16'h0000};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 9'd1, 16'h0001};

    #12 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", beat_cnt, 0);
    check("rst_vec", out_vec, '0);
`ifdef DEMUX_COLLECT_PARITY_EN
    check("rst_parity", vec_parity, 0);
`endif

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_bit = 1'b1; auto_mode = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_valid_vec", out_vec, '0);
    check("idle_valid_busy", busy, 0);

    // Table-driven short sequence
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; clear = tbl[i].clr; auto_mode = tbl[i].am;
      in_valid = tbl[i].vld; in_bit = tbl[i].b; sel = tbl[i].s;
      tick();
      start = 1'b0; clear = 1'b0; in_valid = 1'b0;
      check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_done", i), frame_done, tbl[i].e_done);
      check($sformatf("tbl%0d_cnt", i), beat_cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d_vec", i), out_vec, {240'd0, tbl[i].e_lo});
    end

    // Asynchronous reset mid-frame after 10 beats
    do_clear();
    do_start();
    for (int i = 0; i < 10; i++) beat(1'b1, 8'd0, 1'b1);
    check("pre_arst_cnt", beat_cnt, 10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vec", out_vec, '0);
    check("arst_cnt", beat_cnt, 0);
    check("arst_ready", in_ready, 0);
    #1 rst_n = 1'b1;
    tick();
    check("post_arst_busy", busy, 0);

    // Auto mode full frame, in_bit = index[0]
    do_start();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      beat(1'b1, 8'd0, i[0]);
      if (i < 255 && (frame_done !== 1'b0 || in_ready !== 1'b1)) bad++;
    end
    check("auto_no_early_done", bad, 0);
    check("auto_done", frame_done, 1);
    check("auto_done_ready", in_ready, 0);
    check("auto_done_busy", busy, 0);
    check("auto_done_cnt", beat_cnt, 256);
    exp_vec = {128{2'b10}};
    check("auto_vec", out_vec, exp_vec);

    // start and a beat during DONE are ignored
    start = 1'b1; in_valid = 1'b1; auto_mode = 1'b0; sel = 8'd1; in_bit = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("done_pulse_end", frame_done, 0);
    check("done_start_ignored", busy, 0);
    check("done_beat_ignored", out_vec, exp_vec);

    // Back-to-back frame keeps prior bits until overwritten
    do_start();
    check("b2b_busy", busy, 1);
    check("b2b_keep_vec", out_vec, exp_vec);
    beat(1'b1, 8'd0, 1'b1);
    exp_vec[0] = 1'b1;
    check("b2b_overwrite", out_vec, exp_vec);

    // Clear then addressed-mode frame
    do_clear();
    check("clr_vec", out_vec, '0);
    check("clr_cnt", beat_cnt, 0);
    check("clr_busy", busy, 0);
    do_start();
    beat(1'b0, 8'd255, 1'b1);
    beat(1'b0, 8'd0, 1'b1);
    check("addr_bit0_set", out_vec[0], 1);
    beat(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 252; i++) beat(1'b0, 8'd7, 1'b1);
    check("addr_no_done_255", frame_done, 0);
    check("addr_cnt_255", beat_cnt, 255);
    beat(1'b0, 8'd7, 1'b1);
    exp_vec = '0;
    exp_vec[255] = 1'b1;
    exp_vec[7] = 1'b1;
    check("addr_done", frame_done, 1);
    check("addr_vec", out_vec, exp_vec);
    tick();

    // start mid-frame ignored; clear priority at beat_cnt = 100
    do_clear();
    do_start();
    for (int i = 0; i < 50; i++) beat(1'b1, 8'd0, 1'b1);
    check("cnt_50", beat_cnt, 50);
    start = 1'b1;
    beat(1'b1, 8'd0, 1'b1);
    start = 1'b0;
    check("start_ign_cnt_51", beat_cnt, 51);
    beat(1'b1, 8'd0, 1'b1);
    check("start_ign_cnt_52", beat_cnt, 52);
    for (int i = 0; i < 48; i++) beat(1'b1, 8'd0, 1'b1);
    check("cnt_100", beat_cnt, 100);
    clear = 1'b1; start = 1'b1;
    beat(1'b1, 8'd0, 1'b1);
    clear = 1'b0; start = 1'b0;
    check("clrpri_vec", out_vec, '0);
    check("clrpri_cnt", beat_cnt, 0);
    check("clrpri_busy", busy, 0);
    check("clrpri_ready", in_ready, 0);
    tick();
    check("clrpri_stay_idle", busy, 0);

`ifdef DEMUX_COLLECT_PARITY_EN
    do_start();
    beat(1'b0, 8'd3, 1'b1);
    check("par_one", vec_parity, 1);
    beat(1'b0, 8'd9, 1'b1);
    check("par_two", vec_parity, 0);
    beat(1'b0, 8'd200, 1'b1);
    check("par_three", vec_parity, 1);
    beat(1'b0, 8'd9, 1'b0);
    check("par_overwrite", vec_parity, 0);
    do_clear();
    check("par_clear", vec_parity, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux1to256_collector

// File: doc/demux1to256_collector.md
Name: demux1to256_collector

Overview:
- Sequential 1-to-256 demultiplexer and collector. It is the write-side counterpart of the 256-to-1 bit-select mux.
- Accepts a stream of 1-bit beats over a valid/ready handshake and steers each beat into one bit of a registered 256-bit vector.
- The target bit is either an explicit `sel` index or an internal auto-increment pointer.
- Signals completion once 256 beats have been accepted. The resulting vector is intended to feed a downstream 256-to-1 bit-select mux or other packed-vector consumers.

Parameters:
- N, 256, number of output bits; must be a power of two, ≥2.
- SEL_W, $clog2(N) = 8, width of `sel` and of the internal pointer.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle pulse; begins a frame from IDLE.
- clear  input  1  synchronous clear of the vector and the FSM.
- auto_mode  input  1  1 = write to the internal pointer; 0 = write to `sel`. Sampled on each accepted beat.
- sel  input  SEL_W  target bit index when `auto_mode` = 0.
- in_valid  input  1  beat valid.
- in_bit  input  1  beat data.
- in_ready  output  1  collector can accept a beat.
- out_vec  output  N  collected vector (registered).
- frame_done  output  1  one-cycle pulse when a frame completes.
- busy  output  1  high while in FILL.
- beat_cnt  output  SEL_W+1  beats accepted in the current frame, range 0..N.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State = IDLE.
  - out_vec = 0, ptr = 0, beat_cnt = 0.
  - in_ready = 0, frame_done = 0, busy = 0.
  - Asserting reset mid-frame discards all progress.
- States: IDLE, FILL, DONE.
  - IDLE: in_ready = 0. On start = 1 → FILL; ptr and beat_cnt are set to 0. out_vec is kept, not cleared.
  - FILL: in_ready = 1, busy = 1. A beat is accepted when in_valid && in_ready.
    - Target index idx = auto_mode ? ptr : sel.
    - out_vec[idx] <= in_bit; all other bits hold.
    - ptr and beat_cnt both increment.
    - On the beat that makes beat_cnt = N → DONE. ptr wraps to 0.
  - DONE: lasts exactly one cycle. frame_done = 1, in_ready = 0. Then → IDLE.
- Latency: the updated out_vec bit is visible on the cycle after the handshake cycle. frame_done asserts on the cycle after the Nth handshake.
- Addressed mode (auto_mode = 0):
  - Repeated writes to the same index: last write wins.
  - Every accepted beat counts toward N, including repeats.
  - Bits never written keep their previous value.
- Mixed modes within a frame are legal. ptr advances on every beat regardless of mode.
- start while in FILL or DONE is ignored.
- in_valid while in IDLE or DONE is ignored; no state change.
- clear = 1 (synchronous):
  - out_vec = 0, ptr = 0, beat_cnt = 0, state → IDLE, frame_done = 0.
  - Overrides start and any same-cycle beat.
- No backpressure other than the state-based in_ready. in_ready depends only on state, never combinationally on in_valid.

Optional Feature:
- Macro: DEMUX_COLLECT_PARITY_EN.
- When defined:
  - Extra output port `vec_parity` (1 bit), a register equal to the XOR of out_vec.
  - It is updated in the same cycle out_vec updates (incremental: parity ^= old_bit ^ in_bit).
  - It is 0 after reset and after clear.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `demux_collect_pkg`:
  - N_DEFAULT = 256 and SEL_W_DEFAULT = 8.
  - State enum `collect_state_t` {IDLE, FILL, DONE}.
- One sub-module: `demux_onehot_dec`, a combinational SEL_W → N one-hot write-enable decoder, gated by an accept signal.
- The top module holds the FSM, counters and vector registers.

Test Plan:
- Reset and idle:
  - Assert rst_n = 0 mid-FILL after 10 beats → out_vec = 0, beat_cnt = 0, in_ready = 0 immediately (asynchronous).
  - With in_valid = 1 while in IDLE → out_vec stays 0.
- Auto mode full frame:
  - start, then 256 beats with in_bit = index[0] → out_vec = {128{2'b10}}.
  - frame_done pulses exactly once, one cycle after beat 256; in_ready = 0 during DONE.
- Addressed mode:
  - start; sel = 255, bit 1; sel = 0, bit 1; sel = 0, bit 0; then 253 beats with sel = 7, bit 1.
  - Result: out_vec[255] = 1, out_vec[0] = 0, out_vec[7] = 1, all other bits 0.
  - frame_done after 256 total beats.
- Clear priority: in FILL with beat_cnt = 100, assert clear together with in_valid and start → out_vec = 0, state IDLE, beat_cnt = 0, no write.
- Ignored controls:
  - start pulsed at beat 50 → beat_cnt continues 51, 52, …
  - Back-to-back frames: start on the cycle after DONE → the second frame keeps prior out_vec bits until overwritten.
- Parity (with DEMUX_COLLECT_PARITY_EN):
  - Write 1 into bits 3, 9, 200 → vec_parity = 1.
  - Then overwrite bit 9 with 0 → vec_parity = 0.
